// File: rtl/tx_byte_fifo_if.sv
// tx_byte_fifo_if: printer push side, status and uart_tx launch signals of tx_byte_fifo.
interface tx_byte_fifo_if #(
  parameter int DEPTH_LOG2 = 5
);
  logic                  flush;
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic [7:0]            drop_count;
  logic                  uart_tx_busy;
  logic                  uart_tx_en;
  logic [7:0]            uart_tx_data;
  modport slave (
    input  flush, wr_en, wr_data, uart_tx_busy,
    output full, empty, count, overflow, drop_count, uart_tx_en, uart_tx_data
  );
  modport master (
    output flush, wr_en, wr_data, uart_tx_busy,
    input  full, empty, count, overflow, drop_count, uart_tx_en, uart_tx_data
  );
endinterface

// File: rtl/tx_byte_fifo.sv
// tx_byte_fifo: byte FIFO that paces one uart_tx_en launch per byte on uart_tx_busy.
// Define TX_FIFO_DROP_STATS_EN to build the saturating drop_count counter.
module tx_byte_fifo #(
  parameter int DEPTH_LOG2 = 5,
  parameter int BUSY_WAIT  = 4
) (
  input logic           clk,
  input logic           rst_n,
  tx_byte_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int TW    = $clog2(BUSY_WAIT + 2);
  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;
  state_t                state_q, state_d;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [7:0]            data_q, data_d;
  logic                  en_q, ovf_q;
  logic                  room, push, drop, pop;
  // Room is judged on the registered count only, so a same-cycle pop never frees a slot.
  assign room = count_q != CW'(DEPTH);
  assign push = bus.wr_en && !bus.flush && room;
  assign drop = bus.wr_en && !bus.flush && !room;
  assign pop  = state_q == IDLE && count_q != '0 && !bus.uart_tx_busy && !bus.flush;
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    case (state_q)
      IDLE:    state_d = pop ? WAIT_HI : IDLE;
      WAIT_HI: begin
        timer_d = timer_q + 1'b1;
        if (bus.uart_tx_busy || timer_q == TW'(BUSY_WAIT)) begin
          state_d = WAIT_LO;
          timer_d = '0;
        end
      end
      WAIT_LO: state_d = bus.uart_tx_busy ? WAIT_LO : IDLE;
      default: state_d = IDLE;
    endcase
    // A launched byte is never aborted: flush only skips the busy-rise wait.
    if (bus.flush && state_q != IDLE) begin
      state_d = WAIT_LO;
      timer_d = '0;
    end
  end
  always_comb begin
    wr_ptr_d = bus.flush ? '0 : wr_ptr_q + DEPTH_LOG2'(push);
    rd_ptr_d = bus.flush ? '0 : rd_ptr_q + DEPTH_LOG2'(pop);
    count_d  = bus.flush ? '0 : count_q + CW'(push) - CW'(pop);
    data_d   = pop ? mem_q[rd_ptr_q] : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      en_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      en_q     <= pop;
      ovf_q    <= drop;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end
`ifdef TX_FIFO_DROP_STATS_EN
  logic [7:0] drop_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_q + 8'(drop && drop_q != 8'hff);
  end
  assign bus.drop_count = drop_q;
`else
  assign bus.drop_count = '0;
`endif
  assign bus.full         = !room;
  assign bus.empty        = count_q == '0;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.uart_tx_en   = en_q;
  assign bus.uart_tx_data = data_q;
endmodule

// File: tb/tb_tx_byte_fifo.sv
// tb_tx_byte_fifo: directed scoreboard bench for tx_byte_fifo with a uart_tx busy responder.
module tb_tx_byte_fifo;
  logic clk = 0;
  logic rst_n;
  int   checks = 0, failures = 0;
  int   cyc = 0, pe = 0, n_launch = 0, ov_cnt = 0, n0, o0;
  int   busy_mode = 0, dur = 10, rand_dur = 0, cnt = 0;
  bit   pend = 0, prev_en = 0;
  logic [7:0] exp_q[$];
  int         lt[$];
  tx_byte_fifo_if #(.DEPTH_LOG2(5)) bus();
  tx_byte_fifo #(.DEPTH_LOG2(5), .BUSY_WAIT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // uart_tx model: busy rises one cycle after en and stays high for dur cycles
  always @(posedge clk) begin
    #1;
    if (busy_mode == 0) begin
      cnt = 0;
      pend = 0;
      bus.uart_tx_busy = 1'b0;
    end else if (busy_mode == 2) begin
      bus.uart_tx_busy = 1'b1;
    end else begin
      if (cnt > 0) cnt--;
      if (pend) begin
        cnt = rand_dur != 0 ? int'($urandom_range(1, 20)) : dur;
        pend = 0;
      end
      if (bus.uart_tx_en) pend = 1;
      bus.uart_tx_busy = cnt > 0;
    end
  end
  always @(posedge clk) begin
    #1;
    if (bus.overflow) ov_cnt++;
  end
  always @(posedge clk) begin
    #1;
    if (bus.uart_tx_en) begin
      n_launch++;
      lt.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_launch data=%0h expected no launch", bus.uart_tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.uart_tx_data !== e) begin
          failures++;
          $display("FAIL tx_data got=%0h exp=%0h", bus.uart_tx_data, e);
        end
      end
      if (prev_en) begin
        checks++;
        failures++;
        $display("FAIL en_back_to_back got=1 exp=0");
      end
    end
    prev_en = bus.uart_tx_en;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask
  task automatic push(input logic [7:0] d, input bit acc, input bit fl);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    bus.flush = fl;
    @(posedge clk);
    #1;
    pe = cyc;
    bus.wr_en = 1'b0;
    bus.flush = 1'b0;
    if (acc && !fl) exp_q.push_back(d);
  endtask
  task automatic wait_launches(input int n, input int max);
    for (int i = 0; i < max && lt.size() < n; i++) begin
      @(posedge clk);
      #2;
    end
    chk("launch_wait", lt.size() >= n, 1);
  endtask
  task automatic drain(input int max);
    bit ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(posedge clk);
      #2;
      ok = exp_q.size() == 0 && bus.empty && !bus.uart_tx_busy && !pend;
    end
    chk("drain", ok, 1);
    repeat (8) @(posedge clk);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_en"}, bus.uart_tx_en, 0);
    chk({tag, "_data"}, bus.uart_tx_data, 0);
    chk({tag, "_count"}, bus.count, 0);
    chk({tag, "_full"}, bus.full, 0);
    chk({tag, "_empty"}, bus.empty, 1);
    chk({tag, "_overflow"}, bus.overflow, 0);
    chk({tag, "_drop"}, bus.drop_count, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int exp_drop;
`ifdef TX_FIFO_DROP_STATS_EN
    exp_drop = 8;
`else
    exp_drop = 0;
`endif
    rst_n = 0;
    bus.flush = 0;
    bus.wr_en = 0;
    bus.wr_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    chk_reset_vals("rst");
    // single byte latency
    busy_mode = 1;
    dur = 10;
    lt.delete();
    push(8'h41, 1, 0);
    wait_launches(1, 10);
    if (lt.size() > 0) chk("t1_latency", lt[0] - pe, 1);
    @(negedge clk);
    chk("t1_count", bus.count, 0);
    chk("t1_empty", bus.empty, 1);
    drain(200);
    // overflow with busy held high
    busy_mode = 2;
    repeat (2) @(posedge clk);
    o0 = ov_cnt;
    for (int i = 0; i < 40; i++) begin
      push(8'(i), i < 32, 0);
      if (i == 30) chk("t2_full_at31", bus.full, 0);
      if (i == 31) chk("t2_full_at32", bus.full, 1);
    end
    repeat (3) @(negedge clk);
    chk("t2_overflows", ov_cnt - o0, 8);
    chk("t2_count", bus.count, 32);
    chk("t2_drop", bus.drop_count, exp_drop);
    n0 = n_launch;
    busy_mode = 1;
    dur = 3;
    drain(2000);
    chk("t2_launches", n_launch - n0, 32);
    // busy never rises: timeout pacing
    busy_mode = 0;
    repeat (2) @(posedge clk);
    lt.delete();
    for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i), 1, 0);
    wait_launches(3, 40);
    if (lt.size() >= 3) begin
      chk("t3_gap1", lt[1] - lt[0], 7);
      chk("t3_gap2", lt[2] - lt[1], 7);
    end
    drain(100);
    // flush during transmission
    busy_mode = 1;
    dur = 10;
    n0 = n_launch;
    o0 = ov_cnt;
    push(8'h55, 1, 0);
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 1, 0);
    repeat (2) @(posedge clk);
    push(8'hEE, 0, 1);
    exp_q.delete();
    chk("t4_count_after_flush", bus.count, 0);
    repeat (30) @(negedge clk);
    chk("t4_launches", n_launch - n0, 1);
    chk("t4_no_overflow", ov_cnt - o0, 0);
    chk("t4_empty", bus.empty, 1);
    drain(200);
    // 100 bytes through multiple pointer wraps
    rand_dur = 1;
    n0 = n_launch;
    for (int i = 0; i < 100; i++) begin
      for (int w = 0; w < 500 && bus.full; w++) @(negedge clk);
      push(8'(i * 7 + 3), 1, 0);
    end
    drain(5000);
    chk("t5_launches", n_launch - n0, 100);
    rand_dur = 0;
    // asynchronous reset in WAIT_LO with bytes queued
    busy_mode = 1;
    dur = 15;
    for (int i = 0; i < 11; i++) push(8'h80 + 8'(i), 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    exp_q.delete();
    chk_reset_vals("arst");
    n0 = n_launch;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (25) @(negedge clk);
    chk("t6_no_launch", n_launch - n0, 0);
    chk("t6_empty", bus.empty, 1);
    push(8'h99, 1, 0);
    drain(200);
    chk("t6_relaunch", n_launch - n0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
